mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single SISC memory port between the instruction-fetch requester (IR load path) and the data requester (LOD/STR path).
- Sits between the control/datapath and the memory array. Sequences each access through a fixed number of wait states and returns a one-cycle acknowledge with registered read data.
- Ties between the two requesters are broken round-robin.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 32, memory word width.
- WAIT_CYC, 1, memory wait states per access (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_f  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_W  fetch address (PC).
- if_ack  output  1  one-cycle pulse: fetch complete, rdata valid.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle pulse: data access complete.
- rdata  output  DATA_W  registered read data; valid in the ack cycle and held until the next capture.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  DATA_W  write data to memory.
- mem_we  output  1  memory write enable.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_f low, immediate, async):
  - state = IDLE; all outputs 0; rdata = 0; wait counter = 0.
  - last_served = DATA, so fetch wins the first tie.
- States: IDLE, ACCESS, DONE. Two-bit encoding; unused encodings go to IDLE.
- IDLE:
  - Request sampled at edge k; grant is decided by the request lines at that edge.
  - Only one request high: that port wins.
  - Both high: the port other than last_served wins.
  - On grant, at edge k:
    - latch addr/we/wdata of the winner into mem_addr/mem_we/mem_wdata;
    - record the grant id;
    - load counter = WAIT_CYC;
    - go to ACCESS.
  - With no request: stay in IDLE; mem_we = 0; mem_addr holds its last value.
- ACCESS:
  - mem_addr, mem_wdata and mem_we are held stable.
  - Counter decrements each cycle. At the edge where the counter equals 0:
    - rdata <= mem_rdata (for stores too; the value is don't-care but captured);
    - mem_we <= 0;
    - last_served <= grant id;
    - go to DONE.
  - ACCESS lasts exactly WAIT_CYC+1 cycles.
- DONE:
  - The ack of the granted port is high for exactly this one cycle; the other ack stays 0.
  - Next edge unconditionally returns to IDLE. Requests are not sampled in DONE.
- Latency:
  - The ack cycle begins at edge k+WAIT_CYC+1 (ack is high after that edge).
  - Minimum req-to-next-grant spacing is WAIT_CYC+3 cycles.
- Requester rules:
  - Drop req in the cycle after observing ack.
  - Address and data need only be valid at the grant edge.
- Boundary conditions:
  - Req deasserted mid-ACCESS: the access still completes and ack still pulses.
  - The losing port's request stays pending and is granted at the first IDLE edge after DONE.
  - A fetch and a data request arriving in the same cycle alternate strictly across successive ties.
  - WAIT_CYC = 0: ACCESS lasts 1 cycle.
  - rst_f low mid-ACCESS: mem_we drops immediately, no ack is issued, and the FSM restarts in IDLE.
- busy = (state != IDLE).

Decomposition:
- Shared package sisc_mem_pkg:
  - state encodings ST_IDLE=0, ST_ACCESS=1, ST_DONE=2;
  - port ids PORT_IF=0, PORT_D=1;
  - default ADDR_W/DATA_W.
- Natural sub-module: mem_wait_cnt, a loadable down-counter with a zero flag, width 4. Everything else stays in one module.

Test Plan:
- Reset, then a single fetch: rst_f low, then high; WAIT_CYC=1; if_req=1, if_addr=0x0005, mem_rdata=0x12345678.
  -> Grant at edge k; mem_addr=0x0005 for 2 cycles.
  -> if_ack pulses in the cycle after edge k+2; rdata=0x12345678; d_ack=0.
- Store: d_req=1, d_we=1, d_addr=0x0020, d_wdata=0xDEADBEEF.
  -> mem_we=1 with mem_addr=0x0020 and mem_wdata=0xDEADBEEF for WAIT_CYC+1 cycles.
  -> mem_we=0 in DONE; d_ack pulses once.
- Tie arbitration: after reset, if_req and d_req both held high continuously; each requester drops req for one cycle after its ack and then reasserts.
  -> Grant order IF, D, IF, D; acks alternate; each ack pulse is 1 cycle wide.
- Request withdrawal: d_req dropped one cycle after grant.
  -> Access completes and d_ack still pulses; no second grant without a new req.
- Reset mid-operation: rst_f low during ACCESS.
  -> mem_we, if_ack, d_ack and busy go 0 immediately; state is IDLE after release.
  -> With WAIT_CYC=0, a new fetch completes with ack 1 cycle after the grant edge.

Source files
------------

// File: rtl/sisc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sisc_mem_pkg
// Description : Shared types and constants for the SISC memory-port arbiter.
//               Provides the FSM state encoding, the requester ids, the
//               wait-state counter width and default bus widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sisc_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_cnt
// Description : Loadable 4-bit down-counter with a zero flag, used to time
//               the memory wait states. Load has priority over decrement;
//               the counter saturates at zero.
// Ports       : clk        - system clock
//               rst_f      - asynchronous active-low reset
//               i_load     - load i_load_val this cycle
//               i_load_val - value to load
//               i_dec      - decrement (ignored while zero)
//               o_zero     - counter equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_cnt
  import sisc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_f,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single SISC memory port between the instruction
//               fetch requester and the data (load/store) requester. Each
//               access is held for WAIT_CYC+1 cycles, then a one-cycle ack
//               is returned with registered read data. Ties are broken
//               round-robin against the last served port.
// Ports       : clk, rst_f           - clock, async active-low reset
//               if_req/if_addr/if_ack - fetch request, address, ack pulse
//               d_req/d_we/d_addr/d_wdata/d_ack - data request side
//               rdata                - captured read data
//               mem_addr/mem_wdata/mem_we/mem_rdata - memory array side
//               busy                 - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import sisc_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = 1
)(
  input  logic              clk,
  input  logic              rst_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT_CYC);

  state_t            r_state;
  port_t             r_grant;
  port_t             r_last;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_rdata;
  logic              r_if_ack;
  logic              r_d_ack;

  logic              w_any_req;
  logic              w_grant_d;
  logic              w_start;
  logic              w_cnt_zero;

  // Data wins when it is the only requester, or on a tie when fetch was
  // served last.
  assign w_any_req = if_req | d_req;
  assign w_grant_d = d_req & (~if_req | (r_last == PORT_IF));
  assign w_start   = (r_state == ST_IDLE) & w_any_req;

  mem_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst_f      (rst_f),
    .i_load     (w_start),
    .i_load_val (c_wait_load),
    .i_dec      (r_state == ST_ACCESS),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state     <= ST_IDLE;
      r_grant     <= PORT_IF;
      r_last      <= PORT_D;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rdata     <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mem_we <= 1'b0;
          if (w_any_req) begin
            r_grant    <= w_grant_d ? PORT_D : PORT_IF;
            r_mem_addr <= w_grant_d ? d_addr : if_addr;
            r_mem_we   <= w_grant_d & d_we;
            // A fetch carries no write data; the bus keeps its last value.
            if (w_grant_d) begin
              r_mem_wdata <= d_wdata;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_cnt_zero) begin
            // Captured for stores too so rdata always reflects the port.
            r_rdata  <= mem_rdata;
            r_mem_we <= 1'b0;
            r_last   <= r_grant;
            r_if_ack <= (r_grant == PORT_IF);
            r_d_ack  <= (r_grant == PORT_D);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_we <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A table of
//               request patterns drives a WAIT_CYC=1 instance; expected
//               transactions are queued when driven and compared when the
//               grant and the ack appear. Hand sequences cover request
//               withdrawal, reset during an access and WAIT_CYC=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int W1 = 1;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr;
  logic [31:0] d_wdata;

  logic        if_ack1, d_ack1, mem_we1, busy1;
  logic [31:0] rdata1, mem_wdata1, mem_rdata1;
  logic [15:0] mem_addr1;
  logic        if_ack0, d_ack0, mem_we0, busy0;
  logic [31:0] rdata0, mem_wdata0, mem_rdata0;
  logic [15:0] mem_addr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory contents: a fixed function of the address (0x0005 -> 0x12345678).
  function automatic logic [31:0] mem_f(input logic [15:0] a);
    logic [15:0] x;
    x = a ^ 16'h0005;
    return 32'h12345678 ^ {x, x};
  endfunction

  always_comb mem_rdata1 = mem_f(mem_addr1);
  always_comb mem_rdata0 = mem_f(mem_addr0);

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYC(W1)) u_dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1),
    .rdata(rdata1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack0),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack0),
    .rdata(rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_we(mem_we0),
    .mem_rdata(mem_rdata0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  logic m_prev_busy = 1'b0;
  logic m_prev_ack  = 1'b0;
  logic m_bad       = 1'b0;
  int   m_acc       = 0;

  task automatic push_exp(input logic is_d, input logic we, input logic [15:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.is_d  = is_d;
    e.we    = is_d & we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = mem_f(addr);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst_f) begin
      m_prev_busy = 1'b0;
      m_prev_ack  = 1'b0;
    end else begin
      if (m_prev_ack)
        chk("ack_one_cycle", 64'({if_ack1, d_ack1}), 64'(2'b00));
      if (busy1 && !m_prev_busy) begin
        chk("grant_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          m_e = sb_q[0];
          chk("grant_bus", {15'd0, mem_we1, mem_addr1, m_e.we ? mem_wdata1 : 32'd0},
              {15'd0, m_e.we, m_e.addr, m_e.we ? m_e.wdata : 32'd0});
        end
        m_acc = 0;
        m_bad = 1'b0;
      end
      if (busy1 && !if_ack1 && !d_ack1) begin
        m_acc++;
        if (mem_addr1 != m_e.addr || mem_we1 != m_e.we || (m_e.we && mem_wdata1 != m_e.wdata))
          m_bad = 1'b1;
      end
      if (if_ack1 || d_ack1) begin
        chk("ack_expected", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) begin
          m_e = sb_q.pop_front();
          chk("ack_port", 64'({if_ack1, d_ack1}), m_e.is_d ? 64'(2'b01) : 64'(2'b10));
          chk("rdata", 64'(rdata1), 64'(m_e.rdata));
          chk("access_len", 64'(m_acc), 64'(W1 + 1));
          chk("we_low_in_done", 64'(mem_we1), 64'(0));
          chk("bus_stable", 64'(m_bad), 64'(0));
        end
      end
      m_prev_busy = busy1;
      m_prev_ack  = if_ack1 | d_ack1;
    end
  end

  task automatic wait_ack(input logic is_d);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (is_d ? d_ack1 : if_ack1) got = 1'b1;
    end
    chk(is_d ? "d_ack_in_budget" : "if_ack_in_budget", 64'(got), 64'(1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ifr;
    logic        dr;
    logic        we;
    logic [15:0] ia;
    logic [15:0] da;
    logic [31:0] wd;
    logic        exp_d;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic no_regrant;
    // A pending loser keeps its request (and address) into the next row.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 32'h0,        1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0104, 16'h0204, 32'h11112222, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0108, 16'h0204, 32'h11112222, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0108, 16'h0208, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0208, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h020C, 32'h33334444, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h010C, 16'h0210, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0210, 32'h0,        1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0110, 16'h0000, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0114, 16'h0214, 32'h55556666, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0114, 16'h0000, 32'h0,        1'b0};

    rst_f = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs1", {if_ack1, d_ack1, mem_we1, busy1, rdata1, mem_addr1, 12'd0},
        64'd0);
    chk("rst_wdata1", 64'(mem_wdata1), 64'd0);
    chk("rst_outputs0", {if_ack0, d_ack0, mem_we0, busy0, rdata0, mem_addr0, 12'd0},
        64'd0);
    #3 rst_f = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 64'(busy1), 64'(0));

    // ---- table: arbitration, loads and stores ----
    for (int i = 0; i < 14; i++) begin
      if_req  = vecs[i].ifr;
      d_req   = vecs[i].dr;
      d_we    = vecs[i].we;
      if_addr = vecs[i].ia;
      d_addr  = vecs[i].da;
      d_wdata = vecs[i].wd;
      push_exp(vecs[i].exp_d, vecs[i].we, vecs[i].exp_d ? vecs[i].da : vecs[i].ia, vecs[i].wd);
      wait_ack(vecs[i].exp_d);
      @(posedge clk); #1;
      if (vecs[i].exp_d) d_req = 1'b0;
      else               if_req = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- request withdrawn one cycle after grant ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    push_exp(1'b1, 1'b0, 16'h0400, 32'h0);
    @(posedge clk); #1;
    chk("withdraw_granted", 64'(busy1), 64'(1));
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_ack(1'b1);
    no_regrant = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (n > 0 && busy1) no_regrant = 1'b0;
    end
    chk("no_regrant", 64'(no_regrant), 64'(1));

    // ---- reset in the middle of a store ----
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0500; d_wdata = 32'h55AA55AA;
    push_exp(1'b1, 1'b1, 16'h0500, 32'h55AA55AA);
    @(posedge clk); #1;
    chk("store_we_high", 64'(mem_we1), 64'(1));
    #2 rst_f = 1'b0;
    #1;
    chk("rst_mid_access", 64'({mem_we1, if_ack1, d_ack1, busy1}), 64'(4'b0000));
    sb_q.delete();
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #3;
    rst_f = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_mid_reset", 64'({busy1, if_ack1, d_ack1, busy0}), 64'(4'b0000));

    // ---- WAIT_CYC=0 instance: ack one cycle after the grant edge ----
    if_req = 1'b1; if_addr = 16'h0040;
    push_exp(1'b0, 1'b0, 16'h0040, 32'h0);
    @(posedge clk); #1;
    chk("w0_grant", {46'd0, busy0, if_ack0, mem_addr0}, {46'd0, 1'b1, 1'b0, 16'h0040});
    @(posedge clk); #1;
    chk("w0_ack", {31'd0, if_ack0, rdata0}, {31'd0, 1'b1, mem_f(16'h0040)});
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("w0_ack_pulse", 64'({if_ack0, busy0}), 64'(2'b00));

    for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("sb_empty_at_end", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
